// File: rtl/sync_fifo_if.sv
// Bus bundle between a sync_fifo and its single-clock producer/consumer.
// Latency: none, wires only.
// Backpressure: producer watches wfull/afull, consumer watches rempty/aempty.
//
// Signals: wreq/wdata write side, rreq/rdata read side, flush clear,
// wfull/rempty/afull/aempty status, count occupancy, overflow/underflow
// sticky error flags.
interface sync_fifo_if #(
    parameter int DepthSize = 8,
    parameter int ArraySize = 4
);
    logic                 wreq;
    logic [DepthSize-1:0] wdata;
    logic                 rreq;
    logic [DepthSize-1:0] rdata;
    logic                 flush;
    logic                 wfull;
    logic                 rempty;
    logic                 afull;
    logic                 aempty;
    logic [ArraySize:0]   count;
    logic                 overflow;
    logic                 underflow;

    // User side: issues requests, observes data and status.
    modport master (
        output wreq, wdata, rreq, flush,
        input  rdata, wfull, rempty, afull, aempty, count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  wreq, wdata, rreq, flush,
        output rdata, wfull, rempty, afull, aempty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost flags, sticky errors, flush.
// Latency: write visible (rempty=0) after its edge; rdata 1 cycle after read accept (0 in FWFT).
// Backpressure: writes refused while wfull, reads refused while rempty; refusals set sticky flags.
//
// Ports: clk, rst (async active-high), bus (sync_fifo_if.slave) carrying
// wreq/wdata, rreq/rdata, flush, wfull, rempty, afull, aempty, count,
// overflow, underflow.
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through
// reads; undefined gives registered reads.
module sync_fifo #(
    parameter int DepthSize   = 8,
    parameter int ArraySize   = 4,
    parameter int AfullLevel  = (1 << ArraySize) - 2,
    parameter int AemptyLevel = 2
) (
    input  logic       clk,
    input  logic       rst,
    sync_fifo_if.slave bus
);
    localparam int Depth = 1 << ArraySize;
    localparam int CntW  = ArraySize + 1;

    localparam logic [CntW-1:0] DepthCnt  = CntW'(Depth);
    localparam logic [CntW-1:0] AfullCnt  = CntW'(AfullLevel);
    localparam logic [CntW-1:0] AemptyCnt = CntW'(AemptyLevel);

    // Elaboration-time parameter sanity.
    if (ArraySize < 1) begin : g_bad_array_size
        $error("sync_fifo: ArraySize must be at least 1");
    end
    if (AfullLevel < 1 || AfullLevel > Depth) begin : g_bad_afull
        $error("sync_fifo: AfullLevel out of range 1..Depth");
    end
    if (AemptyLevel < 0 || AemptyLevel > Depth - 1) begin : g_bad_aempty
        $error("sync_fifo: AemptyLevel out of range 0..Depth-1");
    end

    logic [DepthSize-1:0] mem [Depth];

    logic [ArraySize-1:0] wptr;
    logic [ArraySize-1:0] rptr;
    logic [CntW-1:0]      count_q;
    logic [CntW-1:0]      count_next;

    logic wfull_q;
    logic rempty_q;
    logic afull_q;
    logic aempty_q;
    logic overflow_q;
    logic underflow_q;

    logic wacc;
    logic racc;
    logic wrej;
    logic rrej;

    // Accept/reject decisions use the registered flags, which are exact
    // because they were computed from the previous count_next. Flush masks
    // both sides so a flushing cycle neither moves data nor raises errors.
    always_comb begin
        wacc = bus.wreq &  ~wfull_q  & ~bus.flush;
        racc = bus.rreq &  ~rempty_q & ~bus.flush;
        wrej = bus.wreq &   wfull_q  & ~bus.flush;
        rrej = bus.rreq &   rempty_q & ~bus.flush;
    end

    // Occupancy only moves when exactly one side is accepted.
    always_comb begin
        count_next = count_q;
        if (bus.flush) begin
            count_next = '0;
        end else begin
            unique case ({wacc, racc})
                2'b10:   count_next = count_q + CntW'(1);
                2'b01:   count_next = count_q - CntW'(1);
                default: count_next = count_q;
            endcase
        end
    end

    // Count and status flags. Flags derive from count_next so they are
    // correct in the very cycle after the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            wfull_q     <= 1'b0;
            rempty_q    <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q  <= count_next;
            wfull_q  <= (count_next == DepthCnt);
            rempty_q <= (count_next == '0);
            afull_q  <= (count_next >= AfullCnt);
            aempty_q <= (count_next <= AemptyCnt);
            if (bus.flush) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                overflow_q  <= overflow_q  | wrej;
                underflow_q <= underflow_q | rrej;
            end
        end
    end

    // Binary pointers wrap naturally at ArraySize bits; fullness is tracked
    // by count, so no extra wrap bit is carried.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (bus.flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wacc) begin
                wptr <= wptr + ArraySize'(1);
            end
            if (racc) begin
                rptr <= rptr + ArraySize'(1);
            end
        end
    end

    // Storage is left untouched by reset and flush; stale words are
    // unreachable once the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wacc) begin
            mem[wptr] <= bus.wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word presented combinationally; meaningless while rempty.
    assign bus.rdata = mem[rptr];
`else
    logic [DepthSize-1:0] rdata_q;

    // Captured on the accepting edge and held until the next accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (racc) begin
            rdata_q <= mem[rptr];
        end
    end

    assign bus.rdata = rdata_q;
`endif

    assign bus.count     = count_q;
    assign bus.wfull     = wfull_q;
    assign bus.rempty    = rempty_q;
    assign bus.afull     = afull_q;
    assign bus.aempty    = aempty_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo, Depth 4, AfullLevel 3, AemptyLevel 1.
// Registered-read build. Status is packed as
// {count[2:0], wfull, rempty, afull, aempty, overflow, underflow}.
module tb_sync_fifo;
    localparam int DW = 8;
    localparam int AW = 2;

    logic clk;
    logic rst;

    sync_fifo_if #(.DepthSize(DW), .ArraySize(AW)) bus ();

    sync_fifo #(
        .DepthSize  (DW),
        .ArraySize  (AW),
        .AfullLevel (3),
        .AemptyLevel(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] st();
        return 16'({bus.count, bus.wfull, bus.rempty, bus.afull, bus.aempty,
                    bus.overflow, bus.underflow});
    endfunction

    function automatic logic [15:0] ex(input int c, input bit wf, input bit re,
                                       input bit af, input bit ae, input bit ov,
                                       input bit un);
        logic [2:0] c3;
        c3 = 3'(c);
        return 16'({c3, wf, re, af, ae, ov, un});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wreq  = 1'b0;
        bus.rreq  = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.wreq  = 1'b0;
        bus.rreq  = 1'b0;
        bus.flush = 1'b0;
        bus.wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_status", st(), ex(0, 0, 1, 0, 1, 0, 0));
        chk("rst_rdata", 16'(bus.rdata), 16'h00);

        // Fill with 11,22,33,44
        bus.wreq = 1'b1;
        bus.wdata = 8'h11; tick();
        chk("wr1_status", st(), ex(1, 0, 0, 0, 1, 0, 0));
        bus.wdata = 8'h22; tick();
        chk("wr2_status", st(), ex(2, 0, 0, 0, 0, 0, 0));
        bus.wdata = 8'h33; tick();
        chk("wr3_status", st(), ex(3, 0, 0, 1, 0, 0, 0));
        bus.wdata = 8'h44; tick();
        chk("wr4_status", st(), ex(4, 1, 0, 1, 0, 0, 0));

        // Drain in order
        bus.wreq = 1'b0;
        bus.rreq = 1'b1;
        tick();
        chk("rd1_data", 16'(bus.rdata), 16'h11);
        chk("rd1_status", st(), ex(3, 0, 0, 1, 0, 0, 0));
        tick();
        chk("rd2_data", 16'(bus.rdata), 16'h22);
        chk("rd2_status", st(), ex(2, 0, 0, 0, 0, 0, 0));
        tick();
        chk("rd3_data", 16'(bus.rdata), 16'h33);
        chk("rd3_status", st(), ex(1, 0, 0, 0, 1, 0, 0));
        tick();
        chk("rd4_data", 16'(bus.rdata), 16'h44);
        chk("rd4_status", st(), ex(0, 0, 1, 0, 1, 0, 0));

        // Refill, then simultaneous write+read while full
        bus.rreq = 1'b0;
        bus.wreq = 1'b1;
        bus.wdata = 8'h55; tick();
        bus.wdata = 8'h66; tick();
        bus.wdata = 8'h77; tick();
        bus.wdata = 8'h88; tick();
        chk("refill_status", st(), ex(4, 1, 0, 1, 0, 0, 0));
        bus.wdata = 8'h99;
        bus.rreq = 1'b1;
        tick();
        chk("full_wr_rd_data", 16'(bus.rdata), 16'h55);
        chk("full_wr_rd_status", st(), ex(3, 0, 0, 1, 0, 1, 0));

        // Drain remaining 66,77,88; 99 must not appear
        bus.wreq = 1'b0;
        tick();
        chk("drain1_data", 16'(bus.rdata), 16'h66);
        tick();
        chk("drain2_data", 16'(bus.rdata), 16'h77);
        tick();
        chk("drain3_data", 16'(bus.rdata), 16'h88);
        chk("drain3_status", st(), ex(0, 0, 1, 0, 1, 1, 0));

        // Empty with write+read: write accepted, read refused
        bus.wreq = 1'b1;
        bus.wdata = 8'hA5;
        bus.rreq = 1'b1;
        tick();
        chk("empty_wr_rd_status", st(), ex(1, 0, 0, 0, 1, 1, 1));
        chk("empty_wr_rd_rdata_hold", 16'(bus.rdata), 16'h88);
        bus.wreq = 1'b0;
        tick();
        chk("empty_wr_rd_readback", 16'(bus.rdata), 16'hA5);
        chk("empty_wr_rd_after", st(), ex(0, 0, 1, 0, 1, 1, 1));

        // Plain read on empty keeps underflow; then flush clears sticky flags
        tick();
        chk("rd_empty_rdata_hold", 16'(bus.rdata), 16'hA5);
        idle();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush1_status", st(), ex(0, 0, 1, 0, 1, 0, 0));

        // Wrap-around at count=2
        bus.wreq = 1'b1;
        bus.wdata = 8'h01; tick();
        bus.wdata = 8'h02; tick();
        chk("wrap_pre_status", st(), ex(2, 0, 0, 0, 0, 0, 0));
        bus.rreq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wdata = 8'(8'h03 + i);
            tick();
            chk($sformatf("wrap_data%0d", i), 16'(bus.rdata), 16'(8'h01 + i));
            chk($sformatf("wrap_status%0d", i), st(), ex(2, 0, 0, 0, 0, 0, 0));
        end

        // Build count=3 with overflow set: holds 0B,0C; add 0D,0E; overflow; pop
        bus.rreq = 1'b0;
        bus.wdata = 8'h0D; tick();
        bus.wdata = 8'h0E; tick();
        bus.wdata = 8'h0F; tick();
        chk("ovf_status", st(), ex(4, 1, 0, 1, 0, 1, 0));
        bus.wreq = 1'b0;
        bus.rreq = 1'b1;
        tick();
        chk("ovf_pop_data", 16'(bus.rdata), 16'h0B);
        chk("ovf_pop_status", st(), ex(3, 0, 0, 1, 0, 1, 0));

        // Flush with concurrent write: write ignored
        bus.rreq = 1'b0;
        bus.wreq = 1'b1;
        bus.wdata = 8'hEE;
        bus.flush = 1'b1;
        tick();
        idle();
        chk("flush2_status", st(), ex(0, 0, 1, 0, 1, 0, 0));
        tick();
        chk("flush2_hold_status", st(), ex(0, 0, 1, 0, 1, 0, 0));
        chk("flush2_rdata_hold", 16'(bus.rdata), 16'h0B);

        // Async reset mid-cycle at count=2
        bus.wreq = 1'b1;
        bus.wdata = 8'h21; tick();
        bus.wdata = 8'h22; tick();
        bus.wdata = 8'h23; tick();
        bus.wreq = 1'b0;
        bus.rreq = 1'b1;
        tick();
        bus.rreq = 1'b0;
        chk("pre_rst_data", 16'(bus.rdata), 16'h21);
        chk("pre_rst_status", st(), ex(2, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_status", st(), ex(0, 0, 1, 0, 1, 0, 0));
        chk("async_rst_rdata", 16'(bus.rdata), 16'h00);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_status", st(), ex(0, 0, 1, 0, 1, 0, 0));

        // Normal operation after reset; old words are gone
        bus.wreq = 1'b1;
        bus.wdata = 8'h5A;
        tick();
        bus.wreq = 1'b0;
        bus.rreq = 1'b1;
        tick();
        bus.rreq = 1'b0;
        chk("post_rst_data", 16'(bus.rdata), 16'h5A);
        chk("post_rst_final", st(), ex(0, 0, 1, 0, 1, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
